// File: rtl/quad_encoder_emulator_if.sv
// Command/observation bundle for one emulated motor encoder.
// The master drives the motor command and limits; the slave returns encoder phases and state.
interface quad_encoder_emulator_if #(
  parameter int SPEED_W = 16,
  parameter int POS_W   = 32
);
  logic                      en;
  logic [1:0]                pwr;
  logic [SPEED_W-2:0]        vmax;
  logic [SPEED_W-2:0]        accel;
  logic [1:0]                enc;
  logic signed [POS_W-1:0]   position;
  logic signed [SPEED_W-1:0] speed;
  logic                      step_p;

  modport master (
    output en, pwr, vmax, accel,
    input  enc, position, speed, step_p
  );

  modport slave (
    input  en, pwr, vmax, accel,
    output enc, position, speed, step_p
  );
endinterface

// File: rtl/quad_encoder_emulator.sv
// Quadrature-encoder transmitter: ramps a signed speed toward a target set by the 2-bit
// motor command, integrates it in a phase accumulator, and emits one encoder step per wrap.
module quad_encoder_emulator #(
  parameter int DIV_CYCLES = 4,
  parameter int SPEED_W    = 16,
  parameter int PHASE_W    = 16,
  parameter int POS_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  quad_encoder_emulator_if.slave  bus
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam int SX_W  = SPEED_W + 1;
  localparam int EXT_W = PHASE_W + 1 - SPEED_W;

  logic [CNT_W-1:0]   r_presc;
  logic [SPEED_W-1:0] r_speed;
  logic [PHASE_W-1:0] r_phase;
  logic [POS_W-1:0]   r_position;
  logic [1:0]         r_enc;
  logic               r_step_p;

  logic                   w_tick;
  logic signed [SX_W-1:0] w_speed_x;
  logic signed [SX_W-1:0] w_vmax_x;
  logic signed [SX_W-1:0] w_target;
  logic signed [SX_W-1:0] w_rate;
  logic signed [SX_W-1:0] w_diff;
  logic signed [SX_W-1:0] w_mag;
  logic signed [SX_W-1:0] w_slew;
  logic signed [SX_W-1:0] w_sum;
  logic signed [SX_W-1:0] w_sat;
  logic [SPEED_W-1:0]     w_speed_next;
  logic [PHASE_W:0]       w_phase_sum;
  logic                   w_step;
  logic [POS_W-1:0]       w_pos_next;

  assign w_tick = (r_presc == CNT_W'(DIV_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + CNT_W'(1);
    end
  end

  assign w_speed_x = $signed({r_speed[SPEED_W-1], r_speed});
  assign w_vmax_x  = $signed({2'b00, bus.vmax});

  // Target/slew selection and a saturating step toward the target; the step is the
  // smaller of the slew rate and the remaining distance, so the target is never overshot.
  always_comb begin
    w_target = '0;
    w_rate   = $signed({2'b00, bus.accel});
    case (bus.pwr)
      2'b01:   w_target = w_vmax_x;
      2'b10:   w_target = -w_vmax_x;
      2'b11:   w_target = '0;
      default: w_rate   = $signed({4'b0000, bus.accel[SPEED_W-2:2]});
    endcase

    w_diff = w_target - w_speed_x;
    w_mag  = w_diff[SX_W-1] ? -w_diff : w_diff;
    w_slew = (w_rate < w_mag) ? w_rate : w_mag;
    w_sum  = w_diff[SX_W-1] ? (w_speed_x - w_slew) : (w_speed_x + w_slew);

    w_sat = w_sum;
    if (w_sum > w_vmax_x) begin
      w_sat = w_vmax_x;
    end else if (w_sum < -w_vmax_x) begin
      w_sat = -w_vmax_x;
    end

    if (!bus.en) begin
      w_sat = '0;
    end

    w_speed_next = w_sat[SPEED_W-1:0];
  end

  // Carry on a positive add and borrow on a negative add both appear in the top bit.
  assign w_phase_sum = {1'b0, r_phase} + {{EXT_W{w_speed_next[SPEED_W-1]}}, w_speed_next};
  assign w_step      = w_phase_sum[PHASE_W];
  assign w_pos_next  = w_speed_next[SPEED_W-1] ? (r_position - POS_W'(1))
                                               : (r_position + POS_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed    <= '0;
      r_phase    <= '0;
      r_position <= '0;
      r_enc      <= 2'b00;
      r_step_p   <= 1'b0;
    end else begin
      r_step_p <= 1'b0;
      if (w_tick) begin
        r_speed <= w_speed_next;
        r_phase <= w_phase_sum[PHASE_W-1:0];
        if (w_step) begin
          r_position <= w_pos_next;
          r_enc      <= {w_pos_next[1], w_pos_next[1] ^ w_pos_next[0]};
          r_step_p   <= 1'b1;
        end
      end
    end
  end

  assign bus.enc      = r_enc;
  assign bus.position = $signed(r_position);
  assign bus.speed    = $signed(r_speed);
  assign bus.step_p   = r_step_p;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator: ramp, steps, encoder order, enable and reset.
module tb_quad_encoder_emulator;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  quad_encoder_emulator_if #(.SPEED_W(16), .POS_W(32)) bus ();

  quad_encoder_emulator #(
    .DIV_CYCLES(4),
    .SPEED_W(16),
    .PHASE_W(16),
    .POS_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input logic [1:0] pwr, input logic [14:0] vmax, input logic [14:0] accel);
    bus.en    = 1'b1;
    bus.pwr   = pwr;
    bus.vmax  = vmax;
    bus.accel = accel;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance n update ticks (4 clk each) and sample 1 time unit after the tick edge.
  task automatic ticks(input int n);
    repeat (4 * n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.pwr = 2'b00; bus.vmax = '0; bus.accel = '0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.enc !== 2'b00) begin bad++; $display("FAIL reset_enc got=%b want=00", bus.enc); end
    total++; if (bus.position !== 32'sd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", bus.position); end
    total++; if (bus.speed !== 16'sd0) begin bad++; $display("FAIL reset_speed got=%h want=0000", bus.speed); end
    total++; if (bus.step_p !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", bus.step_p); end
  endtask

  task automatic test_forward();
    logic [1:0] exp_enc [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(2'b01, 15'h4000, 15'h4000);
    ticks(1);
    total++; if (bus.speed !== 16'sh4000) begin bad++; $display("FAIL fwd_speed got=%h want=4000", bus.speed); end
    for (int i = 0; i < 4; i++) begin
      ticks((i == 0) ? 3 : 4);
      total++; if (bus.step_p !== 1'b1) begin bad++; $display("FAIL fwd_step%0d got=%b want=1", i, bus.step_p); end
      total++; if (bus.position !== 32'(i + 1)) begin bad++; $display("FAIL fwd_pos%0d got=%0d want=%0d", i, bus.position, i + 1); end
      total++; if (bus.enc !== exp_enc[i]) begin bad++; $display("FAIL fwd_enc%0d got=%b want=%b", i, bus.enc, exp_enc[i]); end
    end
  endtask

  task automatic test_ramp();
    logic [15:0] up   [5] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h4000};
    logic [15:0] brk  [5] = '{16'h3000, 16'h2000, 16'h1000, 16'h0000, 16'h0000};
    logic [15:0] cst  [3] = '{16'h3C00, 16'h3800, 16'h3400};
    do_reset(2'b01, 15'h4000, 15'h1000);
    for (int i = 0; i < 5; i++) begin
      ticks(1);
      total++; if (bus.speed !== up[i]) begin bad++; $display("FAIL ramp_up%0d got=%h want=%h", i, bus.speed, up[i]); end
    end
    bus.pwr = 2'b11;
    for (int i = 0; i < 5; i++) begin
      ticks(1);
      total++; if (bus.speed !== brk[i]) begin bad++; $display("FAIL brake%0d got=%h want=%h", i, bus.speed, brk[i]); end
    end
    bus.pwr = 2'b01;
    ticks(4);
    total++; if (bus.speed !== 16'h4000) begin bad++; $display("FAIL reramp got=%h want=4000", bus.speed); end
    bus.pwr = 2'b00;
    for (int i = 0; i < 3; i++) begin
      ticks(1);
      total++; if (bus.speed !== cst[i]) begin bad++; $display("FAIL coast%0d got=%h want=%h", i, bus.speed, cst[i]); end
    end
  endtask

  task automatic test_reverse();
    do_reset(2'b10, 15'h4000, 15'h4000);
    ticks(1);
    total++; if (bus.speed !== 16'hC000) begin bad++; $display("FAIL rev_speed got=%h want=c000", bus.speed); end
    total++; if (bus.step_p !== 1'b1) begin bad++; $display("FAIL rev_step0 got=%b want=1", bus.step_p); end
    total++; if (bus.position !== -32'sd1) begin bad++; $display("FAIL rev_pos0 got=%0d want=-1", bus.position); end
    total++; if (bus.enc !== 2'b10) begin bad++; $display("FAIL rev_enc0 got=%b want=10", bus.enc); end
    @(posedge clk); #1;
    total++; if (bus.step_p !== 1'b0) begin bad++; $display("FAIL rev_step_width got=%b want=0", bus.step_p); end
    repeat (15) @(posedge clk);
    #1;
    total++; if (bus.position !== -32'sd2) begin bad++; $display("FAIL rev_pos1 got=%0d want=-2", bus.position); end
    total++; if (bus.enc !== 2'b11) begin bad++; $display("FAIL rev_enc1 got=%b want=11", bus.enc); end
    ticks(4);
    total++; if (bus.position !== -32'sd3) begin bad++; $display("FAIL rev_pos2 got=%0d want=-3", bus.position); end
    total++; if (bus.enc !== 2'b01) begin bad++; $display("FAIL rev_enc2 got=%b want=01", bus.enc); end
  endtask

  task automatic test_enable();
    int steps_seen;
    do_reset(2'b01, 15'h4000, 15'h4000);
    ticks(6);
    total++; if (bus.position !== 32'sd1) begin bad++; $display("FAIL en_pre_pos got=%0d want=1", bus.position); end
    bus.en = 1'b0;
    ticks(1);
    total++; if (bus.speed !== 16'sd0) begin bad++; $display("FAIL en_off_speed got=%h want=0000", bus.speed); end
    steps_seen = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (bus.step_p === 1'b1) steps_seen++;
    end
    total++; if (steps_seen !== 0) begin bad++; $display("FAIL en_off_steps got=%0d want=0", steps_seen); end
    total++; if (bus.position !== 32'sd1) begin bad++; $display("FAIL en_off_pos got=%0d want=1", bus.position); end
    total++; if (bus.enc !== 2'b01) begin bad++; $display("FAIL en_off_enc got=%b want=01", bus.enc); end
    bus.en = 1'b1;
    ticks(1);
    total++; if (bus.speed !== 16'h4000) begin bad++; $display("FAIL en_on_speed got=%h want=4000", bus.speed); end
    ticks(1);
    total++; if (bus.position !== 32'sd2) begin bad++; $display("FAIL en_on_pos got=%0d want=2", bus.position); end
    total++; if (bus.enc !== 2'b11) begin bad++; $display("FAIL en_on_enc got=%b want=11", bus.enc); end
  endtask

  task automatic test_clamp();
    do_reset(2'b01, 15'h0100, 15'h7FFF);
    ticks(1);
    total++; if (bus.speed !== 16'h0100) begin bad++; $display("FAIL clamp0 got=%h want=0100", bus.speed); end
    ticks(1);
    total++; if (bus.speed !== 16'h0100) begin bad++; $display("FAIL clamp1 got=%h want=0100", bus.speed); end
    bus.pwr = 2'b10;
    ticks(1);
    total++; if (bus.speed !== 16'hFF00) begin bad++; $display("FAIL clamp_rev got=%h want=ff00", bus.speed); end
    bus.pwr = 2'b01; bus.vmax = '0;
    ticks(1);
    total++; if (bus.speed !== 16'h0000) begin bad++; $display("FAIL vmax0_a got=%h want=0000", bus.speed); end
    ticks(1);
    total++; if (bus.speed !== 16'h0000) begin bad++; $display("FAIL vmax0_b got=%h want=0000", bus.speed); end
    bus.vmax = 15'h4000; bus.accel = 15'h1000;
    ticks(1);
    total++; if (bus.speed !== 16'h1000) begin bad++; $display("FAIL accel_pre got=%h want=1000", bus.speed); end
    bus.accel = '0;
    ticks(2);
    total++; if (bus.speed !== 16'h1000) begin bad++; $display("FAIL accel0 got=%h want=1000", bus.speed); end
  endtask

  task automatic test_async_reset();
    do_reset(2'b01, 15'h4000, 15'h4000);
    ticks(12);
    total++; if (bus.step_p !== 1'b1) begin bad++; $display("FAIL ar_pre_step got=%b want=1", bus.step_p); end
    total++; if (bus.position !== 32'sd3) begin bad++; $display("FAIL ar_pre_pos got=%0d want=3", bus.position); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (bus.enc !== 2'b00) begin bad++; $display("FAIL ar_enc got=%b want=00", bus.enc); end
    total++; if (bus.position !== 32'sd0) begin bad++; $display("FAIL ar_pos got=%0d want=0", bus.position); end
    total++; if (bus.speed !== 16'sd0) begin bad++; $display("FAIL ar_speed got=%h want=0000", bus.speed); end
    total++; if (bus.step_p !== 1'b0) begin bad++; $display("FAIL ar_step got=%b want=0", bus.step_p); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_forward();
    test_ramp();
    test_reverse();
    test_enable();
    test_clamp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
